// File: rtl/jtkunio_objdraw_if.sv
// Graphics ROM request/response bus used by the object draw stage.
// The draw stage is the master: it drives the address and chip select and
// waits for rom_ok before taking rom_data.
interface jtkunio_objdraw_if;
   logic [17:0] rom_addr;
   logic        rom_cs;
   logic        rom_ok;
   logic [31:0] rom_data;

   modport master (output rom_addr, output rom_cs, input rom_ok, input rom_data);
   modport slave  (input rom_addr, input rom_cs, output rom_ok, output rom_data);
endinterface

// File: rtl/jtkunio_objdraw.sv
// Object draw stage: fetches two 8-pixel 4bpp halves of a sprite row from
// graphics ROM, paints them into the hidden half of a double line buffer and
// streams the visible half out to the colour mixer, blanking it behind the
// read pointer.
// Build option JTKUNIO_OBJ_PRIO_EN: first-drawn sprite wins; each pixel is
// read-then-write, doubling the paint time.
module jtkunio_objdraw #(
   parameter logic [7:0] HOFFSET = 8'd0,
   parameter logic [5:0] BLANK   = 6'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pxl_cen,
   input  logic [8:0]        hdump,
   input  logic              hinit,
   input  logic              draw,
   output logic              busy,
   input  logic [12:0]       obj_code,
   input  logic [3:0]        obj_vsub,
   input  logic [8:0]        obj_x,
   input  logic [1:0]        obj_pal,
   input  logic              obj_hflip,
   jtkunio_objdraw_if.master rom,
   output logic [5:0]        pxl
);

`ifdef JTKUNIO_OBJ_PRIO_EN
   localparam int CNT_W = 4;
`else
   localparam int CNT_W = 3;
`endif

   typedef enum logic [1:0] {IDLE, FETCH, PAINT} state_t;

   state_t           st, st_nx;
   logic             bank;
   logic             half;
   logic             ok_wait;
   logic [CNT_W-1:0] cnt;
   logic [12:0]      code_r;
   logic [3:0]       vsub_r;
   logic             hflip_r;
   logic [8:0]       x_r;
   logic [1:0]       pal_r;
   logic [31:0]      data_p0;
   logic [5:0]       mem [0:511];
   logic [5:0]       rd_p0;
   logic             hblank_p0;

   logic             accept, paint_last, wr_slot, prio_ok, we_draw;
   logic [2:0]       pix_idx, src_bit;
   logic [3:0]       pen;
   logic [8:0]       xw;

   // 4bpp pen of one pixel: bit j of each plane byte, MSB first on screen
   function automatic logic [3:0] pen_of(input logic [31:0] d, input logic [2:0] j);
      return {d[{2'b11, ~j}], d[{2'b10, ~j}], d[{2'b01, ~j}], d[{2'b00, ~j}]};
   endfunction

   assign accept     = (st == FETCH) && ok_wait && rom.rom_ok;
   assign paint_last = (st == PAINT) && (cnt == '1);
   assign pix_idx    = cnt[CNT_W-1 -: 3];
   assign src_bit    = hflip_r ? ~pix_idx : pix_idx;
   assign pen        = pen_of(data_p0, src_bit);
   assign xw         = x_r + {1'b0, HOFFSET} + {5'd0, half, pix_idx};
   assign rom.rom_addr = {code_r, half ^ hflip_r, vsub_r};

`ifdef JTKUNIO_OBJ_PRIO_EN
   logic [3:0] tgt_p0;
   assign wr_slot = cnt[0];
   assign prio_ok = (tgt_p0 == 4'd0);
`else
   assign wr_slot = 1'b1;
   assign prio_ok = 1'b1;
`endif

   // Pixels at or beyond x=256 are clipped; a line start aborts the sprite
   assign we_draw = (st == PAINT) && wr_slot && !hinit && (pen != 4'd0) && !xw[8] && prio_ok;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st <= IDLE;
      else      st <= st_nx;
   end

   // Next state and handshake outputs
   always_comb begin
      st_nx      = st;
      busy       = (st != IDLE);
      rom.rom_cs = (st == FETCH);
      case (st)
         IDLE:    if (draw) st_nx = FETCH;
         FETCH:   if (hinit) st_nx = IDLE;
                  else if (accept) st_nx = PAINT;
         PAINT:   if (hinit) st_nx = IDLE;
                  else if (paint_last) st_nx = half ? IDLE : FETCH;
         default: st_nx = IDLE;
      endcase
   end

   // Control: bank swap, descriptor fields that form the ROM address, counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank    <= 1'b0;
         half    <= 1'b0;
         ok_wait <= 1'b0;
         cnt     <= '0;
         code_r  <= '0;
         vsub_r  <= '0;
         hflip_r <= 1'b0;
      end else begin
         if (hinit) bank <= ~bank;
         case (st)
            IDLE: if (draw) begin
               code_r  <= obj_code;
               vsub_r  <= obj_vsub;
               hflip_r <= obj_hflip;
               half    <= 1'b0;
               ok_wait <= 1'b0;
            end
            // the address must sit for one clk before rom_ok is trusted
            FETCH: begin
               ok_wait <= 1'b1;
               cnt     <= '0;
            end
            PAINT: begin
               cnt <= cnt + CNT_W'(1);
               if (paint_last) begin
                  half    <= 1'b1;
                  ok_wait <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Data-only descriptor fields and the accepted ROM word
   always_ff @(posedge clk) begin
      if (st == IDLE && draw) begin
         x_r   <= obj_x;
         pal_r <= obj_pal;
      end
      if (accept) data_p0 <= rom.rom_data;
   end

   // Line buffer: draw side on ~bank, readout side reads and blanks bank
   always_ff @(posedge clk) begin
      if (we_draw) mem[{~bank, xw[7:0]}] <= {pal_r, pen};
      if (pxl_cen) begin
         rd_p0 <= mem[{bank, hdump[7:0]}];
         if (!hdump[8]) mem[{bank, hdump[7:0]}] <= BLANK;
      end
`ifdef JTKUNIO_OBJ_PRIO_EN
      if (st == PAINT && !cnt[0]) tgt_p0 <= mem[{~bank, xw[7:0]}][3:0];
`endif
   end

   // p0 -> output: register the read value one pixel later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hblank_p0 <= 1'b0;
         pxl       <= '0;
      end else if (pxl_cen) begin
         hblank_p0 <= hdump[8];
         pxl       <= hblank_p0 ? BLANK : rd_p0;
      end
   end

endmodule

// File: tb/tb_jtkunio_objdraw.sv
// Bench for jtkunio_objdraw: a ROM responder with random latency, a
// line-buffer reference model painted column by column, and readout sweeps.
module tb_jtkunio_objdraw;
   localparam logic [7:0] HOFFSET = 8'd0;
   localparam logic [5:0] BLANK   = 6'd0;
`ifdef JTKUNIO_OBJ_PRIO_EN
   localparam int PAINT_CLKS  = 16;
   localparam int ABORT_COLS  = 1;
`else
   localparam int PAINT_CLKS  = 8;
   localparam int ABORT_COLS  = 3;
`endif

   logic        clk, rst, pxl_cen, hinit, draw, busy, obj_hflip;
   logic [8:0]  hdump, obj_x;
   logic [12:0] obj_code;
   logic [3:0]  obj_vsub;
   logic [1:0]  obj_pal;
   logic [5:0]  pxl;

   jtkunio_objdraw_if rom_if ();

   jtkunio_objdraw #(.HOFFSET(HOFFSET), .BLANK(BLANK)) dut (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .hdump(hdump), .hinit(hinit),
      .draw(draw), .busy(busy), .obj_code(obj_code), .obj_vsub(obj_vsub),
      .obj_x(obj_x), .obj_pal(obj_pal), .obj_hflip(obj_hflip), .rom(rom_if),
      .pxl(pxl)
   );

   int total = 0;
   int bad   = 0;

   logic [5:0]  mdl [0:1][0:255];
   logic        mbank;

   logic [12:0] cur_code;
   logic [3:0]  cur_vsub;
   logic        cur_hflip;
   logic [31:0] cur_d0, cur_d1;
   int          cur_lat;
   int          fetch_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference painter: screen column c of the 16-wide sprite shows source
   // column c (or 15-c when mirrored); source columns 0..7 come from ROM half 0
   task automatic paint_model(input logic b, input logic [8:0] x, input logic [1:0] pal,
                              input logic hf, input logic [31:0] d0, input logic [31:0] d1,
                              input int ncols);
      for (int c = 0; c < ncols; c++) begin
         int s, j, xs;
         logic [31:0] d;
         logic [3:0]  pen;
         s   = hf ? 15 - c : c;
         d   = (s < 8) ? d0 : d1;
         j   = s % 8;
         pen = {d[31-j], d[23-j], d[15-j], d[7-j]};
         xs  = (int'(x) + int'(HOFFSET) + c) % 512;
         if (pen != 4'd0 && xs < 256) begin
`ifdef JTKUNIO_OBJ_PRIO_EN
            if (mdl[b][xs][3:0] == 4'd0) mdl[b][xs] = {pal, pen};
`else
            mdl[b][xs] = {pal, pen};
`endif
         end
      end
   endtask

   // ROM responder: checks each new request address, answers after cur_lat clks
   initial begin
      logic prev_cs;
      int   wcnt;
      prev_cs = 1'b0;
      wcnt    = 0;
      rom_if.rom_ok   = 1'b0;
      rom_if.rom_data = '0;
      forever begin
         @(negedge clk);
         if (rom_if.rom_cs && !prev_cs) begin
            chk("rom_addr", {14'd0, rom_if.rom_addr},
                {14'd0, cur_code, fetch_n[0] ^ cur_hflip, cur_vsub});
            fetch_n++;
            wcnt = 0;
         end
         if (rom_if.rom_cs) begin
            if (wcnt >= cur_lat) begin
               rom_if.rom_ok   = 1'b1;
               rom_if.rom_data = rom_if.rom_addr[4] ? cur_d1 : cur_d0;
            end else begin
               rom_if.rom_ok   = 1'b0;
               rom_if.rom_data = $urandom;
            end
            wcnt++;
         end else begin
            rom_if.rom_ok   = 1'b0;
            rom_if.rom_data = $urandom;
         end
         prev_cs = rom_if.rom_cs;
      end
   end

   task automatic pulse_hinit();
      @(negedge clk);
      hinit = 1'b1;
      @(negedge clk);
      hinit = 1'b0;
      mbank = ~mbank;
   endtask

   task automatic draw_sprite(input logic [12:0] code, input logic [3:0] vsub, input logic [8:0] x,
                              input logic [1:0] pal, input logic hf, input logic [31:0] d0,
                              input logic [31:0] d1, input int lat, input bit abort,
                              input bit with_hinit);
      int   falls, n;
      logic prev;
      cur_code = code; cur_vsub = vsub; cur_hflip = hf;
      cur_d0 = d0; cur_d1 = d1; cur_lat = lat; fetch_n = 0;
      @(negedge clk);
      obj_code = code; obj_vsub = vsub; obj_x = x; obj_pal = pal; obj_hflip = hf;
      draw = 1'b1;
      if (with_hinit) hinit = 1'b1;
      @(negedge clk);
      draw = 1'b0;
      if (with_hinit) begin
         hinit = 1'b0;
         mbank = ~mbank;
      end
      chk("busy_on", busy, 1);
      falls = 0; prev = 1'b1; n = 0;
      while (falls < 2 && n < 200) begin
         @(negedge clk);
         n++;
         if (prev && !rom_if.rom_cs) falls++;
         prev = rom_if.rom_cs;
         if (abort && falls == 1) begin
            repeat (3) @(negedge clk);
            hinit = 1'b1;
            @(negedge clk);
            hinit = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_cs", rom_if.rom_cs, 0);
            paint_model(~mbank, x, pal, hf, d0, d1, ABORT_COLS);
            mbank = ~mbank;
            return;
         end
      end
      if (falls < 2) begin
         chk("fetch_timeout", 0, 1);
         return;
      end
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("paint_len", n, PAINT_CLKS);
      paint_model(~mbank, x, pal, hf, d0, d1, 16);
   endtask

   // Read the visible bank across the line; pxl lags the read by one pxl_cen
   task automatic sweep(input bit do_chk);
      logic [5:0] prev_e, e;
      bit         have;
      have = 1'b0;
      prev_e = BLANK;
      for (int h = 0; h < 264; h++) begin
         @(negedge clk);
         hdump   = h[8:0];
         pxl_cen = 1'b1;
         if (h < 256) begin
            e = mdl[mbank][h];
            mdl[mbank][h] = BLANK;
         end else begin
            e = BLANK;
         end
         @(negedge clk);
         pxl_cen = 1'b0;
         if (have && do_chk) chk("pxl", {26'd0, pxl}, {26'd0, prev_e});
         prev_e = e;
         have = 1'b1;
      end
   endtask

   initial begin
      int n;
      logic flag;
      logic [12:0] rc;
      logic [3:0]  rv;
      logic [8:0]  rx;
      logic [1:0]  rp;
      logic        rh;
      logic [31:0] ra, rb;

      rst = 1'b0; pxl_cen = 1'b0; hinit = 1'b0; draw = 1'b0; hdump = '0;
      obj_code = '0; obj_vsub = '0; obj_x = '0; obj_pal = '0; obj_hflip = 1'b0;
      cur_code = '0; cur_vsub = '0; cur_hflip = 1'b0; cur_d0 = '0; cur_d1 = '0;
      cur_lat = 0; fetch_n = 0; mbank = 1'b0;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 256; i++) mdl[b][i] = BLANK;

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_cs", rom_if.rom_cs, 0);
      chk("rst_addr", {14'd0, rom_if.rom_addr}, 0);
      chk("rst_pxl", {26'd0, pxl}, 0);
      rst = 1'b1;

      // reset in the middle of painting
      cur_code = 13'h0aa; cur_vsub = 4'd2; cur_hflip = 1'b0;
      cur_d0 = 32'hffffffff; cur_d1 = 32'hffffffff; cur_lat = 1; fetch_n = 0;
      @(negedge clk);
      obj_code = cur_code; obj_vsub = cur_vsub; obj_x = 9'd8; obj_pal = 2'd1; obj_hflip = 1'b0;
      draw = 1'b1;
      @(negedge clk);
      draw = 1'b0;
      n = 0;
      while (rom_if.rom_cs && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("rst_fetch_timeout", 0, 1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_cs", rom_if.rom_cs, 0);
      chk("mr_pxl", {26'd0, pxl}, 0);
      @(negedge clk);
      rst = 1'b1;
      mbank = 1'b0;
      flag = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (busy || rom_if.rom_cs) flag = 1'b1;
      end
      chk("idle_after_rst", flag, 0);

      // flush both banks so the model and the buffer start blank
      sweep(1'b0);
      pulse_hinit();
      sweep(1'b0);
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 256; i++) mdl[b][i] = BLANK;

      // plain 16-pixel row, pen 1 on palette 2
      draw_sprite(13'h0123, 4'd5, 9'd16, 2'd2, 1'b0, 32'h000000ff, 32'h000000ff, 3, 1'b0, 1'b0);
      pulse_hinit();
      sweep(1'b1);

      // mirrored: leftmost source pixel lands at the right edge
      draw_sprite(13'h0123, 4'd5, 9'd16, 2'd2, 1'b1, 32'h00000080, 32'h00000000, 3, 1'b0, 1'b0);
      pulse_hinit();
      sweep(1'b1);

      // right-edge clipping
      draw_sprite(13'h1abc, 4'd9, 9'd252, 2'd1, 1'b0, 32'hffffffff, 32'hffffffff, 0, 1'b0, 1'b0);
      pulse_hinit();
      sweep(1'b1);

      // overlap: pen 3 first, pen 5 second
      draw_sprite(13'h0040, 4'd0, 9'd40, 2'd1, 1'b0, 32'h0000ffff, 32'h0000ffff, 2, 1'b0, 1'b0);
      draw_sprite(13'h0041, 4'd1, 9'd40, 2'd3, 1'b0, 32'h00ff00ff, 32'h00ff00ff, 1, 1'b0, 1'b0);
      pulse_hinit();
      sweep(1'b1);

      // abort by hinit during paint, then an immediate new draw
      draw_sprite(13'h0777, 4'd3, 9'd100, 2'd2, 1'b0, 32'hffffffff, 32'hffffffff, 1, 1'b1, 1'b0);
      draw_sprite(13'h0778, 4'd4, 9'd60, 2'd1, 1'b1, 32'h12345678, 32'h9abcdef0, 2, 1'b0, 1'b0);
      sweep(1'b1);
      pulse_hinit();
      sweep(1'b1);

      // hinit together with draw: new sprite lands in the new draw bank
      draw_sprite(13'h0100, 4'd6, 9'd10, 2'd0, 1'b0, 32'hf0f0f0f0, 32'h0f0f0f0f, 0, 1'b0, 1'b0);
      draw_sprite(13'h0101, 4'd7, 9'd200, 2'd3, 1'b0, 32'hffff0000, 32'h0000ffff, 3, 1'b0, 1'b1);
      sweep(1'b1);
      pulse_hinit();
      sweep(1'b1);

      // random lines
      for (int ln = 0; ln < 6; ln++) begin
         int ns;
         ns = $urandom_range(1, 4);
         for (int k = 0; k < ns; k++) begin
            rc = 13'($urandom);
            rv = 4'($urandom);
            rx = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(240, 511)) : 9'($urandom_range(0, 250));
            rp = 2'($urandom);
            rh = 1'($urandom);
            ra = $urandom & $urandom;
            rb = $urandom & $urandom;
            draw_sprite(rc, rv, rx, rp, rh, ra, rb, $urandom_range(0, 3), 1'b0, 1'b0);
         end
         pulse_hinit();
         sweep(1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
